sram_1rw1r_cfg: RTL and testbench
=================================

Name: sram_1rw1r_cfg

Overview:
Synthesisable, parametrised successor to the fixed 32x256 1RW1R SRAM behavioural model. It provides one read/write port and one read-only port on a single clock. It adds configurable width, depth and byte-mask granularity, an optional output register stage, defined read-during-write collision handling, and a hardware clear-on-reset sequencer. It sits in the sram macros library as the drop-in memory for register files and scratchpads wherever a hard macro is not used.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width; RAM_DEPTH = 1 << ADDR_WIDTH (local, not overridable).
- NUM_WMASKS, DATA_WIDTH/8, write-mask bits; one bit per byte lane.
- OUT_REG, 0, 1 = extra output register; read latency becomes 2 instead of 1.
- WRITE_FIRST, 1, collision policy: 1 = port 1 sees new data, 0 = port 1 sees old data.
- INIT_CLEAR, 1, 1 = zero every word after reset before accepting requests.

Ports:
- clk0 in 1: single clock for both ports; all activity on posedge.
- rst in 1: asynchronous, active-high reset.
- csb0 in 1: port 0 chip select, active low.
- web0 in 1: port 0 write enable, active low.
- wmask0 in NUM_WMASKS: port 0 byte write mask.
- addr0 in ADDR_WIDTH: port 0 address.
- din0 in DATA_WIDTH: port 0 write data.
- dout0 out DATA_WIDTH: port 0 read data.
- dout0_valid out 1: one-cycle pulse marking new dout0.
- csb1 in 1: port 1 chip select, active low.
- addr1 in ADDR_WIDTH: port 1 address.
- dout1 out DATA_WIDTH: port 1 read data.
- dout1_valid out 1: one-cycle pulse marking new dout1.
- collision out 1: pulse aligned with dout1_valid when that read collided with a port 0 write.
- init_busy out 1: high while the clear sequencer runs.

Behaviour:
- Reset (async assert): dout0 = dout1 = 0; dout0_valid = dout1_valid = collision = 0; init counter = 0; init_busy = INIT_CLEAR. Memory contents are not reset directly.
- Init FSM states: INIT, READY.
  - rst deassert with INIT_CLEAR=1 -> INIT. With INIT_CLEAR=0 -> READY.
  - INIT writes zero to word cnt each posedge, cnt 0..RAM_DEPTH-1.
  - After writing word RAM_DEPTH-1 -> READY. init_busy falls on that same edge, so it is high for exactly RAM_DEPTH cycles.
  - Reset asserted mid-INIT restarts the sequence at cnt 0.
- Requests while init_busy=1 are ignored: no writes, no valids, no collision.
- Port 0 write (csb0=0, web0=0): byte lane i of mem[addr0] takes din0[8i+7:8i] at the posedge when wmask0[i]=1.
  - Lanes with wmask0[i]=0 keep their old value.
  - wmask0=0 is a legal no-op.
  - A write never drives dout0 or dout0_valid.
- Port 0 read (csb0=0, web0=1): dout0 = mem[addr0] with latency L = 1+OUT_REG cycles; dout0_valid pulses with it.
- Port 1 read (csb1=0): dout1 = mem[addr1] with latency L; dout1_valid pulses with it.
- Data hold: when no read completes, dout0/dout1 hold their last value. The block never emits X.
- Collision: port 0 write and port 1 read in the same cycle with addr0==addr1 and wmask0 != 0.
  - WRITE_FIRST=1: dout1 = merged word (masked lanes from din0, other lanes old).
  - WRITE_FIRST=0: dout1 = old word.
  - In both modes collision pulses with dout1_valid. Memory always gets the write.
- Back-to-back: each port accepts one request every cycle, fully pipelined. Read after write to the same address on a later cycle returns the new data.
- OUT_REG=1: the stage-1 result is registered once more. Valids and collision are delayed identically.
- Width rules: wmask0 lane i maps to bits [8i+7:8i]. Address is used modulo RAM_DEPTH (full range, no out-of-range case).

Decomposition:
- Package sram_cfg_pkg:
  - init_state_t enum {INIT, READY}.
  - Function to compute the merged byte-masked word (shared by the write path and the bypass path).
  - Localparam BYTE = 8.
- Sub-module sram_init_seq: INIT/READY FSM and address counter. Outputs init_busy, init_we, init_addr.
- The top level muxes init traffic over port 0 and holds the memory array, the collision comparator and the output pipeline.

Test Plan:
- INIT_CLEAR=1, ADDR_WIDTH=4: release rst -> init_busy high exactly 16 cycles. Then a port 1 read of every address returns 0 with dout1_valid one cycle after the request.
- Write addr0=5, din0=0xAABBCCDD, wmask0=4'b1111, then write 0x11223344 with wmask0=4'b0101 -> a port 0 read of 5 returns 0xAA22CC44 one cycle later (two with OUT_REG=1).
- Same-cycle write addr 3 = 0xDEADBEEF (mask 1111, old value 0) plus port 1 read addr 3 -> WRITE_FIRST=1: dout1=0xDEADBEEF, collision=1. WRITE_FIRST=0: dout1=0, collision=1. The next read returns 0xDEADBEEF in both modes.
- Port 0 and port 1 reads every cycle of addresses 0..15 after preload (mem[i]=i) -> dout values 0..15 on consecutive cycles and valids continuously high. No collision.
- Assert rst at init cycle 7 for 1 cycle -> dout/valids forced to 0 immediately, init restarts, init_busy high for a further 16 cycles. A write issued during init has no effect.
- Idle cycles after a read of 0x1234 -> dout1 holds 0x1234 and dout1_valid stays 0. A write with wmask0=0 leaves memory unchanged.

Source files
------------

// File: rtl/sram_cfg_pkg.sv
// rtl/sram_cfg_pkg.sv - shared types and byte-merge helper for sram_1rw1r_cfg
package sram_cfg_pkg;

  localparam int BYTE           = 8;
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_MASKS      = MAX_DATA_WIDTH / BYTE;

  typedef enum logic {INIT, READY} init_state_t;

  // Callers zero-extend into the widest word and truncate the result back.
  function automatic logic [MAX_DATA_WIDTH-1:0] merge_word(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_MASKS-1:0]      mask
  );
    logic [MAX_DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < MAX_MASKS; i++) begin
      if (mask[i]) result[i*BYTE +: BYTE] = new_word[i*BYTE +: BYTE];
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// rtl/sram_init_seq.sv - post-reset clear sequencer: walks every address once in INIT
module sram_init_seq
  import sram_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  init_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (INIT_CLEAR != 0) ? INIT : READY;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_busy  = 1'b0;
    init_we    = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        init_we   = 1'b1;
        cnt_next  = cnt + 1'b1;
        if (cnt == '1) state_next = READY;
      end
      default: ;
    endcase
  end

  assign init_addr = cnt;

endmodule

// File: rtl/sram_1rw1r_cfg.sv
// rtl/sram_1rw1r_cfg.sv - configurable 1RW1R SRAM with byte masks, collision bypass and clear-on-reset
module sram_1rw1r_cfg
  import sram_cfg_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_WMASKS  = DATA_WIDTH / 8,
  parameter int OUT_REG     = 0,
  parameter int WRITE_FIRST = 1,
  parameter int INIT_CLEAR  = 1
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision,
  output logic                  init_busy
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  sram_init_seq #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INIT_CLEAR(INIT_CLEAR)
  ) u_init_seq (
    .clk      (clk0),
    .rst      (rst),
    .init_busy(init_busy),
    .init_we  (init_we),
    .init_addr(init_addr)
  );

  logic req_wr, req_rd0, req_rd1, hit;
  assign req_wr  = ~init_busy & ~csb0 & ~web0;
  assign req_rd0 = ~init_busy & ~csb0 &  web0;
  assign req_rd1 = ~init_busy & ~csb1;
  assign hit     = req_wr & req_rd1 & (addr0 == addr1) & (|wmask0);

  logic [DATA_WIDTH-1:0] old0, merged;
  assign old0   = mem[addr0];
  assign merged = DATA_WIDTH'(merge_word(MAX_DATA_WIDTH'(old0), MAX_DATA_WIDTH'(din0),
                                         MAX_MASKS'(wmask0)));

  // The clear sequencer owns port 0 while it runs.
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  assign we    = init_we | req_wr;
  assign waddr = init_busy ? init_addr : addr0;
  assign wdata = init_busy ? '0 : merged;

  always_ff @(posedge clk0) begin
    if (we) mem[waddr] <= wdata;
  end

  logic                  v0_s1, v1_s1, c_s1;
  logic [DATA_WIDTH-1:0] d0_s1, d1_s1;

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      v0_s1 <= 1'b0;
      v1_s1 <= 1'b0;
      c_s1  <= 1'b0;
      d0_s1 <= '0;
      d1_s1 <= '0;
    end else begin
      v0_s1 <= req_rd0;
      v1_s1 <= req_rd1;
      c_s1  <= hit;
      if (req_rd0) d0_s1 <= old0;
      if (req_rd1) d1_s1 <= (hit && (WRITE_FIRST != 0)) ? merged : mem[addr1];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  v0_s2, v1_s2, c_s2;
      logic [DATA_WIDTH-1:0] d0_s2, d1_s2;

      always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
          v0_s2 <= 1'b0;
          v1_s2 <= 1'b0;
          c_s2  <= 1'b0;
          d0_s2 <= '0;
          d1_s2 <= '0;
        end else begin
          v0_s2 <= v0_s1;
          v1_s2 <= v1_s1;
          c_s2  <= c_s1;
          if (v0_s1) d0_s2 <= d0_s1;
          if (v1_s1) d1_s2 <= d1_s1;
        end
      end

      assign dout0       = d0_s2;
      assign dout0_valid = v0_s2;
      assign dout1       = d1_s2;
      assign dout1_valid = v1_s2;
      assign collision   = c_s2;
    end else begin : g_no_out_reg
      assign dout0       = d0_s1;
      assign dout0_valid = v0_s1;
      assign dout1       = d1_s1;
      assign dout1_valid = v1_s1;
      assign collision   = c_s1;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1rw1r_cfg.sv
// tb/tb_sram_1rw1r_cfg.sv - bench for sram_1rw1r_cfg: two configurations on shared stimulus
module tb_sram_1rw1r_cfg;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NM    = 4;
  localparam int DEPTH = 16;

  logic          clk0 = 1'b0;
  logic          rst  = 1'b0;
  logic          csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [NM-1:0] wmask0 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] din0 = '0;

  logic [DW-1:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic          a_v0, a_v1, a_coll, a_busy, b_v0, b_v1, b_coll, b_busy;

  always #5 clk0 = ~clk0;

  sram_1rw1r_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM),
                   .OUT_REG(0), .WRITE_FIRST(1), .INIT_CLEAR(1)) dut_a (
    .clk0(clk0), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(a_dout0), .dout0_valid(a_v0), .csb1(csb1), .addr1(addr1),
    .dout1(a_dout1), .dout1_valid(a_v1), .collision(a_coll), .init_busy(a_busy));

  sram_1rw1r_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM),
                   .OUT_REG(1), .WRITE_FIRST(0), .INIT_CLEAR(1)) dut_b (
    .clk0(clk0), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(b_dout0), .dout0_valid(b_v0), .csb1(csb1), .addr1(addr1),
    .dout1(b_dout1), .dout1_valid(b_v1), .collision(b_coll), .init_busy(b_busy));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word array, init countdown, and expected output registers.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;
  logic [DW-1:0] ea_d0, ea_d1, eb_d0, eb_d1, pb_d0, pb_d1;
  logic          ea_v0, ea_v1, ea_c, eb_v0, eb_v1, eb_c, pb_v0, pb_v1, pb_c, e_busy;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_left = DEPTH;
    {ea_d0, ea_d1, eb_d0, eb_d1, pb_d0, pb_d1} = '0;
    {ea_v0, ea_v1, ea_c, eb_v0, eb_v1, eb_c, pb_v0, pb_v1, pb_c} = '0;
    e_busy = 1'b1;
  endtask

  task automatic check_all();
    chk("a_dout0", a_dout0, ea_d0);   chk("a_dout0_valid", a_v0, ea_v0);
    chk("a_dout1", a_dout1, ea_d1);   chk("a_dout1_valid", a_v1, ea_v1);
    chk("a_collision", a_coll, ea_c); chk("a_init_busy", a_busy, e_busy);
    chk("b_dout0", b_dout0, eb_d0);   chk("b_dout0_valid", b_v0, eb_v0);
    chk("b_dout1", b_dout1, eb_d1);   chk("b_dout1_valid", b_v1, eb_v1);
    chk("b_collision", b_coll, eb_c); chk("b_init_busy", b_busy, e_busy);
  endtask

  task automatic step(input logic c0, input logic w0, input logic [3:0] m, input logic [3:0] a0,
                      input logic [31:0] d, input logic c1, input logic [3:0] a1);
    logic        busy, rd0, rd1, wr, coll;
    logic [31:0] neww;
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    busy = (m_left > 0);
    rd0  = !busy && !c0 && w0;
    rd1  = !busy && !c1;
    wr   = !busy && !c0 && !w0;
    coll = wr && rd1 && (a0 == a1) && (m != 4'h0);
    neww = m_mem[a0];
    for (int i = 0; i < 4; i++)
      if (m[i]) neww = (neww & ~(32'hFF << (8 * i))) | (d & (32'hFF << (8 * i)));
    eb_v0 = pb_v0; if (pb_v0) eb_d0 = pb_d0;
    eb_v1 = pb_v1; if (pb_v1) eb_d1 = pb_d1;
    eb_c  = pb_c;
    pb_v0 = rd0;   if (rd0) pb_d0 = m_mem[a0];
    pb_v1 = rd1;   if (rd1) pb_d1 = m_mem[a1];
    pb_c  = coll;
    ea_v0 = rd0;   if (rd0) ea_d0 = m_mem[a0];
    ea_v1 = rd1;   if (rd1) ea_d1 = coll ? neww : m_mem[a1];
    ea_c  = coll;
    if (wr) m_mem[a0] = neww;
    if (busy) m_left--;
    e_busy = (m_left > 0);
    @(posedge clk0);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
  endtask

  typedef struct {
    logic c0, w0; logic [3:0] m, a0; logic [31:0] d; logic c1; logic [3:0] a1;
    logic [31:0] ad0; logic av0; logic [31:0] ad1; logic av1, ac;
    logic [31:0] bd0; logic bv0; logic [31:0] bd1; logic bv1, bc;
  } vec_t;

  vec_t vecs [15];

  task automatic check_vec(input int i);
    chk($sformatf("vec%0d_a_dout0", i), a_dout0, vecs[i].ad0);
    chk($sformatf("vec%0d_a_v0", i), a_v0, vecs[i].av0);
    chk($sformatf("vec%0d_a_dout1", i), a_dout1, vecs[i].ad1);
    chk($sformatf("vec%0d_a_v1", i), a_v1, vecs[i].av1);
    chk($sformatf("vec%0d_a_coll", i), a_coll, vecs[i].ac);
    chk($sformatf("vec%0d_b_dout0", i), b_dout0, vecs[i].bd0);
    chk($sformatf("vec%0d_b_v0", i), b_v0, vecs[i].bv0);
    chk($sformatf("vec%0d_b_dout1", i), b_dout1, vecs[i].bd1);
    chk($sformatf("vec%0d_b_v1", i), b_v1, vecs[i].bv1);
    chk($sformatf("vec%0d_b_coll", i), b_coll, vecs[i].bc);
  endtask

  initial begin
    int          n;
    logic        rc0, rw0, rc1;
    logic [3:0]  rm, ra0, ra1;
    logic [31:0] rd;

    // Expected outputs of the A (latency 1, write-first) and B (latency 2, read-first) instances.
    vecs[0]  = '{1'b0, 1'b0, 4'hF, 4'd5, 32'hAABBCCDD, 1'b1, 4'd0,
                 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'h5, 4'd5, 32'h11223344, 1'b1, 4'd0,
                 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'd5,
                 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'd3,
                 32'hAA22CC44, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1,
                 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'd3,
                 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0,
                 32'hAA22CC44, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 4'd7, 32'hFFFFFFFF, 1'b0, 4'd7,
                 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0,
                 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'hF, 4'd9, 32'h00001234, 1'b1, 4'd0,
                 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd9,
                 32'hDEADBEEF, 1'b0, 32'h1234, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0,
                 32'hDEADBEEF, 1'b0, 32'h1234, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h1234, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 4'd9, 32'hFFFFFFFF, 1'b1, 4'd0,
                 32'hDEADBEEF, 1'b0, 32'h1234, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h1234, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'd0,
                 32'h1234, 1'b1, 32'h1234, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h1234, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'h1, 4'd3, 32'h000000AA, 1'b0, 4'd3,
                 32'h1234, 1'b0, 32'hDEADBEAA, 1'b1, 1'b1, 32'h1234, 1'b1, 32'h1234, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0,
                 32'h1234, 1'b0, 32'hDEADBEAA, 1'b0, 1'b0, 32'h1234, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd3,
                 32'h1234, 1'b0, 32'hDEADBEAA, 1'b1, 1'b0, 32'h1234, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0,
                 32'h1234, 1'b0, 32'hDEADBEAA, 1'b0, 1'b0, 32'h1234, 1'b0, 32'hDEADBEAA, 1'b1, 1'b0};

    #2 rst = 1'b1;
    model_reset();
    @(posedge clk0);
    #1;
    check_all();
    @(negedge clk0);
    rst = 1'b0;

    n = 0;
    while (a_busy && n < 40) begin
      idle();
      n++;
    end
    chk("init_busy_cycles", n, 16);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].c0, vecs[i].w0, vecs[i].m, vecs[i].a0, vecs[i].d, vecs[i].c1, vecs[i].a1);
      check_vec(i);
    end

    // Async reset must clear held outputs immediately, then restart init mid-sequence.
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) idle();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk0);
    @(negedge clk0);
    rst = 1'b0;
    step(1'b0, 1'b0, 4'hF, 4'd2, 32'hFFFFFFFF, 1'b1, 4'd0);
    n = 1;
    while (a_busy && n < 40) begin
      idle();
      n++;
    end
    chk("init_busy_after_restart", n, 16);

    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 4'(i));
      chk($sformatf("clear_read%0d", i), a_dout1, 32'h0);
      chk($sformatf("clear_valid%0d", i), a_v1, 1'b1);
    end
    idle();

    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 4'hF, 4'(i), 32'(i), 1'b1, 4'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'(i));
      chk($sformatf("stream_p0_%0d", i), a_dout0, 32'(i));
      chk($sformatf("stream_p1_%0d", i), a_dout1, 32'(i));
      chk($sformatf("stream_valids_%0d", i), {a_v0, a_v1, a_coll}, 3'b110);
    end
    idle();
    idle();

    for (int k = 0; k < 400; k++) begin
      rc0 = ($urandom_range(0, 3) == 0);
      rw0 = 1'($urandom_range(0, 1));
      rc1 = ($urandom_range(0, 3) == 0);
      rm  = 4'($urandom_range(0, 15));
      ra0 = 4'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 2) == 0) ? ra0 : 4'($urandom_range(0, 15));
      rd  = $urandom;
      step(rc0, rw0, rm, ra0, rd, rc1, ra1);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
